// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the SCPU: byte-enabled word RAM plus an MMIO page with
// a 64-bit cycle counter, a scratch register and a debug-TX byte FIFO.
module dmem_mmio_responder #(
  parameter int          RAM_AW    = 10,
  parameter logic [15:0] MMIO_BASE = 16'hFFFF,
  parameter int          FIFO_AW   = 3,
  parameter string       INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  wea,
  input  logic [31:0] addr,
  input  logic [31:0] dina,
  output logic [31:0] douta,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam logic [7:0] OFF_CYCLE_LO = 8'h00;
  localparam logic [7:0] OFF_CYCLE_HI = 8'h04;
  localparam logic [7:0] OFF_TX_DATA  = 8'h08;
  localparam logic [7:0] OFF_STATUS   = 8'h0C;
  localparam logic [7:0] OFF_SCRATCH  = 8'h10;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

  logic                mmio;
  logic [7:0]          off;
  logic [RAM_AW-1:0]   ram_idx;

  logic [31:0]         ram [0:(1<<RAM_AW)-1];
  logic [31:0]         ram_q_p1;
  logic                sel_ram_p1;
  logic [31:0]         mmio_q_p1;
  logic [31:0]         mmio_rd;

  logic [63:0]         cycle;
  logic [31:0]         hi_latch;
  logic [31:0]         scratch;

  logic [7:0]          fifo_mem [0:(1<<FIFO_AW)-1];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count, count_nxt;
  logic [3:0]          count_4;
  logic                overflow;
  logic                full, empty;
  logic                push_req, push_ok, pop, ovf_set, ovf_clr;

  logic                unused_addr;

  assign mmio        = (addr[31:16] == MMIO_BASE);
  assign off         = addr[7:0];
  assign ram_idx     = addr[RAM_AW+1:2];
  assign unused_addr = ^{addr[15:8], addr[1:0]};

  // Stage p0 -> p1: RAM read-before-write and MMIO read capture
  always_ff @(posedge clk) begin
    ram_q_p1 <= ram[ram_idx];
    for (int i = 0; i < 4; i++) begin
      if (!mmio && wea[i]) ram[ram_idx][8*i +: 8] <= dina[8*i +: 8];
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (off)
      OFF_CYCLE_LO: mmio_rd = cycle[31:0];
      OFF_CYCLE_HI: mmio_rd = hi_latch;
      OFF_STATUS:   mmio_rd = {24'b0, count_4, 1'b0, overflow, full, empty};
      OFF_SCRATCH:  mmio_rd = scratch;
      default:      mmio_rd = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_ram_p1 <= 1'b0;
      mmio_q_p1  <= '0;
    end else begin
      sel_ram_p1 <= !mmio;
      mmio_q_p1  <= mmio_rd;
    end
  end

  // RAM data is not reset, so the select register alone forces douta to 0 in reset
  assign douta = sel_ram_p1 ? ram_q_p1 : mmio_q_p1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle    <= '0;
      hi_latch <= '0;
      scratch  <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (mmio && off == OFF_CYCLE_LO) hi_latch <= cycle[63:32];
      for (int i = 0; i < 4; i++) begin
        if (mmio && off == OFF_SCRATCH && wea[i]) scratch[8*i +: 8] <= dina[8*i +: 8];
      end
    end
  end

  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);
  assign count_4  = 4'(count);
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? fifo_mem[rd_ptr] : 8'h00;

  assign pop      = tx_valid & tx_ready;
  assign push_req = mmio && off == OFF_TX_DATA && wea[0];
  assign push_ok  = push_req && (!full || pop);
  assign ovf_set  = push_req && !push_ok;
  assign ovf_clr  = mmio && off == OFF_STATUS && wea[0] && dina[2];

  always_comb begin
    count_nxt = count;
    case ({push_ok, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= dina[7:0];
  end

  // A same-edge overflow set takes priority over the W1C clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      count <= count_nxt;
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: stimulus queues expected read data and
// TX bytes, a monitor compares them as douta and the TX handshake are presented.
module tb_dmem_mmio_responder;

  logic        clk;
  logic        rst;
  logic [3:0]  wea;
  logic [31:0] addr;
  logic [31:0] dina;
  logic [31:0] douta;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       nm_q[$];
  logic [7:0]  tx_q[$];
  logic        chk_req = 1'b0;
  logic        chk_p1  = 1'b0;

  localparam logic [31:0] A_LO   = 32'hFFFF_0000;
  localparam logic [31:0] A_HI   = 32'hFFFF_0004;
  localparam logic [31:0] A_TX   = 32'hFFFF_0008;
  localparam logic [31:0] A_STAT = 32'hFFFF_000C;
  localparam logic [31:0] A_SCR  = 32'hFFFF_0010;

  dmem_mmio_responder dut (
    .clk      (clk),
    .rst      (rst),
    .wea      (wea),
    .addr     (addr),
    .dina     (dina),
    .douta    (douta),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  initial begin
    clk = 1'b0;
    #15;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  task automatic access(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                        input bit chk, input logic [31:0] e, input string n);
    wea     = w;
    addr    = a;
    dina    = d;
    chk_req = chk;
    if (chk) begin
      exp_q.push_back(e);
      nm_q.push_back(n);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
    access(4'h0, a, 32'h0, 1'b1, e, n);
  endtask

  task automatic idle();
    access(4'h0, 32'h0, 32'h0, 1'b0, 32'h0, "");
  endtask

  always @(posedge clk) chk_p1 <= chk_req;

  // Monitor: douta one edge after a checked access, TX byte on every handshake
  always @(negedge clk) begin
    if (chk_p1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL douta_unexpected: got %h expected nothing", douta);
      end else begin
        automatic logic [31:0] e = exp_q.pop_front();
        automatic string n = nm_q.pop_front();
        if (douta !== e) begin
          bad++;
          $display("FAIL %s: got %h expected %h", n, douta, e);
        end
      end
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      total++;
      if (tx_q.size() == 0) begin
        bad++;
        $display("FAIL tx_unexpected: got %h expected no byte", tx_data);
      end else begin
        automatic logic [7:0] t = tx_q.pop_front();
        if (tx_data !== t) begin
          bad++;
          $display("FAIL tx_byte: got %h expected %h", tx_data, t);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; wea = 4'h0; addr = 32'h0; dina = 32'h0; tx_ready = 1'b0;
    #5 rst = 1'b0;
    #5;
    check("reset_douta", douta, 32'h0);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("reset_tx_data", {24'b0, tx_data}, 32'h0);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    rd(A_STAT, 32'h0000_0001, "reset_status");

    // RAM byte lanes and aliasing
    access(4'hF, 32'h40, 32'hDEAD_BEEF, 1'b0, 32'h0, "");
    access(4'h1, 32'h40, 32'h0000_0011, 1'b1, 32'hDEAD_BEEF, "ram_wr_returns_old");
    rd(32'h40,   32'hDEAD_BE11, "ram_byte_merge");
    rd(32'h1040, 32'hDEAD_BE11, "ram_alias");

    // Read-before-write
    access(4'hF, 32'h80, 32'hA5A5_A5A5, 1'b0, 32'h0, "");
    access(4'hF, 32'h80, 32'h1234_5678, 1'b1, 32'hA5A5_A5A5, "rbw_old");
    rd(32'h80, 32'h1234_5678, "rbw_new");

    // Scratch, unmapped and write-only reads
    access(4'hF, A_SCR, 32'h1122_3344, 1'b0, 32'h0, "");
    access(4'h4, A_SCR, 32'h00AA_0000, 1'b0, 32'h0, "");
    rd(A_SCR, 32'h11AA_3344, "scratch_lane");
    rd(32'hFFFF_1210, 32'h11AA_3344, "scratch_page_alias");
    rd(32'hFFFF_0020, 32'h0, "unmapped_read");
    rd(A_TX, 32'h0, "txdata_reads_zero");

    // FIFO overflow and in-order drain
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      access(4'h1, A_TX, 32'h41 + i, 1'b0, 32'h0, "");
      if (i < 8) tx_q.push_back(8'(8'h41 + i));
    end
    rd(A_STAT, 32'h0000_0086, "status_overflow_full");
    tx_ready = 1'b1;
    repeat (8) idle();
    check("tx_drained_all", tx_q.size(), 32'h0);
    access(4'h1, A_STAT, 32'h4, 1'b1, 32'h0000_0005, "w1c_returns_old");
    rd(A_STAT, 32'h0000_0001, "status_after_w1c");

    // Full + push + pop on one edge
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      access(4'h1, A_TX, 32'h50 + i, 1'b0, 32'h0, "");
      tx_q.push_back(8'(8'h50 + i));
    end
    rd(A_STAT, 32'h0000_0082, "status_full");
    tx_ready = 1'b1;
    access(4'h1, A_TX, 32'h58, 1'b0, 32'h0, "");
    tx_q.push_back(8'h58);
    tx_ready = 1'b0;
    rd(A_STAT, 32'h0000_0082, "full_push_pop_count");
    tx_ready = 1'b1;
    repeat (8) idle();
    check("tx_drained_all2", tx_q.size(), 32'h0);
    rd(A_STAT, 32'h0000_0001, "status_no_overflow");

    // Mid-operation reset discards the FIFO
    tx_ready = 1'b0;
    access(4'h1, A_TX, 32'h60, 1'b0, 32'h0, "");
    access(4'h1, A_TX, 32'h61, 1'b0, 32'h0, "");
    idle();
    rst = 1'b0;
    #1;
    check("midreset_tx_valid", {31'b0, tx_valid}, 32'h0);
    check("midreset_douta", douta, 32'h0);
    rst = 1'b1;
    #1;

    // Cycle counter
    repeat (10) idle();
    rd(A_LO, 32'd10, "cycle_lo_10");
    rd(A_HI, 32'd0,  "cycle_hi_0");
    rd(A_STAT, 32'h0000_0001, "status_after_midreset");
    force dut.cycle = 64'h0000_0000_FFFF_FFFF;
    #1;
    release dut.cycle;
    idle();
    rd(A_LO, 32'd0, "cycle_lo_wrap");
    rd(A_HI, 32'd1, "cycle_hi_carry");
    rd(A_LO, 32'd2, "cycle_lo_after_wrap");

    idle();
    idle();
    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
